// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter between N_REQ byte sources. Requesters
//   are granted round-robin. The winner's byte is latched and a one-cycle
//   start is issued. The transmitter's busy window is then tracked until the
//   frame ends. Completed frames are counted. A transmitter that never raises
//   busy after a start is flagged with err, and that byte is dropped.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   req         per-requester request level, held until ack
//   req_data    byte for requester i on bits [8i+7:8i]
//   ack         one-hot one-cycle pulse: byte from requester i latched
//   tx_busy     busy flag from the UART transmitter
//   tx_start    one-cycle start pulse to the transmitter
//   tx_data     byte being transmitted, held until the next grant
//   grant_id    index of the current/last granted requester
//   state       0 IDLE, 1 START, 2 WAIT_BUSY, 3 WAIT_DONE
//   byte_count  completed frames, wrapping
//   done        one-cycle pulse when a frame completes
//   err         one-cycle pulse when tx_busy never rose after a start
//   idle        high while state is IDLE
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_W         = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [2:0]         grant_id,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   byte_count,
  output logic               done,
  output logic               err,
  output logic               idle
);

  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [2:0]       r_ptr, w_ptr;
  logic [TW-1:0]    r_timer, w_timer;
  logic [N_REQ-1:0] r_ack, w_ack;
  logic             r_tx_start, w_tx_start;
  logic [7:0]       r_tx_data, w_tx_data;
  logic [2:0]       r_grant_id, w_grant_id;
  logic [CNT_W-1:0] r_count, w_count;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             r_idle, w_idle;

  // round-robin search
  logic             w_found;
  logic [2:0]       w_sel;
  logic [3:0]       w_sum;

  // First asserted request at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + 4'(i);
      if (w_sum >= 4'(N_REQ)) w_sum = w_sum - 4'(N_REQ);
      if (!w_found && req[w_sum[2:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[2:0];
      end
    end
  end

  always_comb begin
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_timer    = r_timer;
    w_ack      = '0;
    w_tx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_grant_id = r_grant_id;
    w_count    = r_count;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy && w_found) begin
          w_state        = S_START;
          w_tx_data      = req_data[8*w_sel +: 8];
          w_grant_id     = w_sel;
          w_ack[w_sel]   = 1'b1;
          w_tx_start     = 1'b1;
          w_ptr          = (w_sel == 3'(N_REQ - 1)) ? '0 : w_sel + 3'd1;
        end
      end
      S_START: begin
        w_timer = '0;
        w_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state = S_WAIT_DONE;
        end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
          w_count = r_count + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // idle is registered, so it follows the state being entered
    w_idle = (w_state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_timer    <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_ptr      <= w_ptr;
      r_timer    <= w_timer;
      r_ack      <= w_ack;
      r_tx_start <= w_tx_start;
      r_tx_data  <= w_tx_data;
      r_grant_id <= w_grant_id;
      r_count    <= w_count;
      r_done     <= w_done;
      r_err      <= w_err;
      r_idle     <= w_idle;
    end
  end

  assign ack        = r_ack;
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant_id;
  assign state      = r_state;
  assign byte_count = r_count;
  assign done       = r_done;
  assign err        = r_err;
  assign idle       = r_idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural transmitter model drives tx_busy.
// Stimulus pushes expected grant/done/err events into a queue. A monitor pops
// and compares each one as the DUT presents it. A second DUT with CNT_W=4
// shares all inputs so that the counter wrap is observable.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [31:0]   req_data = '0;
  logic          tx_busy = 1'b0;

  logic [NR-1:0] ack, ack2;
  logic          tx_start, tx_start2;
  logic [7:0]    tx_data, tx_data2;
  logic [2:0]    grant_id, grant_id2;
  logic [1:0]    state, state2;
  logic [13:0]   byte_count;
  logic [3:0]    byte_count2;
  logic          done, done2, err, err2, idle, idle2;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(NR), .START_TIMEOUT(TO), .CNT_W(14)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .state(state), .byte_count(byte_count),
    .done(done), .err(err), .idle(idle)
  );

  uart_tx_arbiter #(.N_REQ(NR), .START_TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack2),
    .tx_busy(tx_busy), .tx_start(tx_start2), .tx_data(tx_data2),
    .grant_id(grant_id2), .state(state2), .byte_count(byte_count2),
    .done(done2), .err(err2), .idle(idle2)
  );

  // transmitter model: busy rises 2 cycles after tx_start, holds busy_len cycles
  logic model_en = 1'b1;
  logic force_busy = 1'b0;
  int   busy_len = 5;
  int   rise_cnt = 0;
  int   hold_cnt = 0;

  always @(negedge clk) begin
    if (force_busy) begin
      tx_busy = 1'b1; rise_cnt = 0; hold_cnt = 1;
    end else if (!model_en) begin
      tx_busy = 1'b0; rise_cnt = 0; hold_cnt = 0;
    end else if (tx_start) begin
      rise_cnt = 2;
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin tx_busy = 1'b1; hold_cnt = busy_len; end
    end else if (tx_busy) begin
      hold_cnt--;
      if (hold_cnt <= 0) tx_busy = 1'b0;
    end
  end

  // scoreboard
  typedef struct {
    int kind;  // 0 grant, 1 done, 2 err
    int id;
    int data;
    int cnt;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  total = 0, bad = 0;
  int  n_ack = 0, n_done = 0, n_err = 0;
  int  exp_ack = 0, exp_done = 0, exp_err = 0, exp_cnt = 0;
  int  cyc = 0, start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_g(input int id, input int data);
    ev_t e; e.kind = 0; e.id = id; e.data = data; e.cnt = 0;
    q.push_back(e); exp_ack++;
  endtask

  task automatic push_d();
    ev_t e; exp_cnt++; e.kind = 1; e.id = 0; e.data = 0; e.cnt = exp_cnt;
    q.push_back(e); exp_done++;
  endtask

  task automatic push_e();
    ev_t e; e.kind = 2; e.id = 0; e.data = 0; e.cnt = exp_cnt;
    q.push_back(e); exp_err++;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (ack != '0) begin
      n_ack++;
      if (q.size() == 0) chk("unexpected_ack", 32'(ack), 0);
      else begin
        mon_e = q.pop_front();
        chk("ev_kind_grant", 0, mon_e.kind);
        chk("grant_ack", 32'(ack), 32'(1) << mon_e.id);
        chk("grant_id", 32'(grant_id), mon_e.id);
        chk("grant_tx_data", 32'(tx_data), mon_e.data);
        chk("grant_tx_start", 32'(tx_start), 1);
        start_cyc = cyc;
      end
    end
    if (done) begin
      n_done++;
      if (q.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin
        mon_e = q.pop_front();
        chk("ev_kind_done", 1, mon_e.kind);
        chk("byte_count", 32'(byte_count), mon_e.cnt);
        chk("byte_count_w4", 32'(byte_count2), mon_e.cnt & 15);
        chk("done_idle", 32'(idle), 1);
      end
    end
    if (err) begin
      n_err++;
      if (q.size() == 0) chk("unexpected_err", 32'(err), 0);
      else begin
        mon_e = q.pop_front();
        chk("ev_kind_err", 2, mon_e.kind);
        chk("err_latency", cyc - start_cyc, TO + 1);
        chk("err_byte_count", 32'(byte_count), mon_e.cnt);
        chk("err_state", 32'(state), 0);
      end
    end
  end

  // which: 0 acks, 1 dones, 2 errs
  task automatic wait_n(input int which, input int target, input int budget);
    int seen;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      seen = (which == 0) ? n_ack : (which == 1) ? n_done : n_err;
      if (seen >= target) return;
    end
    seen = (which == 0) ? n_ack : (which == 1) ? n_done : n_err;
    total++; bad++;
    $display("FAIL wait_event_%0d: saw %0d need %0d", which, seen, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // 1. reset with all requests pending
    rst = 1'b1; req = 4'hF;
    req_data = {8'hFF, 8'h70, 8'h61, 8'h6E};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    push_g(0, 8'h6E); push_d();
    rst = 1'b0;
    @(negedge clk);
    chk("release_ack", 32'(ack), 32'h1);
    chk("release_tx_start", 32'(tx_start), 1);
    req = '0;
    wait_n(1, exp_done, 200);

    // 2. single long send from requester 2
    busy_len = 12500;
    req_data[23:16] = 8'h53;
    push_g(2, 8'h53); push_d();
    req = 4'b0100;
    wait_n(0, exp_ack, 50);
    req = '0;
    wait_n(1, exp_done, 13000);
    chk("single_state", 32'(state), 0);
    chk("single_grant_id", 32'(grant_id), 2);
    repeat (5) @(negedge clk);
    chk("single_tx_data_hold", 32'(tx_data), 8'h53);

    // reset so the pointer restarts at 0
    rst = 1'b1; exp_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst2_byte_count", 32'(byte_count), 0);
    rst = 1'b0;

    // 3. round robin with all requests held
    busy_len = 5;
    req_data = {8'hFF, 8'h70, 8'h61, 8'h6E};
    push_g(0, 8'h6E); push_d();
    push_g(1, 8'h61); push_d();
    push_g(2, 8'h70); push_d();
    push_g(3, 8'hFF); push_d();
    push_g(0, 8'h6E); push_d();
    req = 4'hF;
    wait_n(0, exp_ack, 400);
    req = '0;
    wait_n(1, exp_done, 100);

    // 4. fairness: req[0] held, req[3] raised mid-frame wins next
    busy_len = 40;
    req_data[7:0] = 8'h11; req_data[31:24] = 8'hA5;
    push_g(0, 8'h11); push_d();
    push_g(3, 8'hA5); push_d();
    req = 4'b0001;
    wait_n(0, exp_ack - 1, 50);
    repeat (10) @(negedge clk);
    chk("fair_mid_state", 32'(state), 3);
    req[3] = 1'b1;
    wait_n(0, exp_ack, 200);
    req = '0;
    wait_n(1, exp_done, 200);

    // 5. start timeout, then pointer continues after requester 1
    model_en = 1'b0;
    req_data[15:8] = 8'h3C;
    push_g(1, 8'h3C); push_e();
    req = 4'b0010;
    wait_n(0, exp_ack, 50);
    req = '0;
    wait_n(2, exp_err, 60);
    model_en = 1'b1; busy_len = 5;
    req_data[23:16] = 8'hC3;
    push_g(2, 8'hC3); push_d();
    push_g(1, 8'h3C); push_d();
    req = 4'b0110;
    wait_n(0, exp_ack - 1, 50);
    req = 4'b0010;
    wait_n(0, exp_ack, 100);
    req = '0;
    wait_n(1, exp_done, 100);

    // 6a. reset during WAIT_DONE
    busy_len = 40;
    req_data[7:0] = 8'h5A;
    push_g(0, 8'h5A);
    req = 4'b0001;
    wait_n(0, exp_ack, 50);
    req = '0;
    repeat (10) @(negedge clk);
    chk("wd_state_before_rst", 32'(state), 3);
    rst = 1'b1; exp_cnt = 0;
    @(negedge clk);
    chk("wd_rst_state", 32'(state), 0);
    chk("wd_rst_byte_count", 32'(byte_count), 0);
    chk("wd_rst_tx_busy_still_high", 32'(tx_busy), 1);
    rst = 1'b0;
    for (int k = 0; k < 100 && tx_busy; k++) @(negedge clk);
    @(negedge clk);

    // 6b. transmitter occupied while idle blocks grants
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    begin
      int a0;
      a0 = n_ack;
      repeat (20) @(negedge clk);
      chk("busy_blocks_ack", n_ack - a0, 0);
      chk("busy_idle", 32'(idle), 1);
    end
    push_g(2, 8'h77); push_d();
    force_busy = 1'b0;
    wait_n(0, exp_ack, 50);
    req = '0;
    wait_n(1, exp_done, 100);

    // 6c. sixteen more frames: 4-bit counter wraps to 0 then 1
    busy_len = 3;
    req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    rd = req_data;
    for (int k = 0; k < 16; k++) begin
      int id;
      id = (3 + k) % 4;
      push_g(id, 32'(rd[8*id +: 8]));
      push_d();
    end
    req = 4'hF;
    wait_n(0, exp_ack, 16 * 25);
    req = '0;
    wait_n(1, exp_done, 100);
    chk("final_count_w4", 32'(byte_count2), 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter (12 MHz clk, 9600 baud, busy/idle handshake) between N_REQ byte sources.
- Grants requesters round-robin and latches the winner's byte. It issues a one-cycle start to the transmitter, then tracks the transmitter's busy window until the frame completes.
- Maintains a wrapping count of bytes sent and flags transmitters that never go busy.

Parameters:
N_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, clk cycles allowed for tx_busy to rise after tx_start
CNT_W, 14, width of byte_count

Ports:
clk  input  1  system clock, 12 MHz, rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester request level; held until ack
req_data  input  8*N_REQ  byte for requester i on bits [8i+7:8i]
ack  output  N_REQ  one-hot, one-cycle pulse: byte from requester i latched
tx_busy  input  1  busy flag from UART transmitter
tx_start  output  1  one-cycle pulse to transmitter
tx_data  output  8  byte to transmit; stable from tx_start until return to IDLE
grant_id  output  3  index of current/last granted requester
state  output  2  FSM state: 0 IDLE, 1 START, 2 WAIT_BUSY, 3 WAIT_DONE
byte_count  output  CNT_W  completed frames, wraps 2^CNT_W-1 -> 0
done  output  1  one-cycle pulse when a frame completes
err  output  1  one-cycle pulse on start timeout
idle  output  1  high when state==IDLE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ack=0, tx_start=0, tx_data=8'h00, grant_id=0, byte_count=0, done=0, err=0, idle=1. The round-robin pointer resets to 0, and the timer resets to 0.
- Reset has priority over everything. A reset during any state returns to IDLE on the next edge and drops tx_start/ack/done/err immediately. Reset does not wait for tx_busy to fall.
- IDLE, no grant: if tx_busy=1 (transmitter already occupied), no grant occurs regardless of req.
- IDLE, grant: if tx_busy=0 and |req, select the first asserted req at or after the pointer, wrapping modulo N_REQ. On that edge:
  - state<=START, tx_data<=req_data[sel], grant_id<=sel, ack[sel]<=1, tx_start<=1.
  - pointer<=(sel+1) mod N_REQ.
- Grant latency: req sampled high in IDLE -> ack and tx_start high in the next cycle. Back-to-back: the next grant can occur in the first IDLE cycle after done.
- START (1 cycle): on exit, ack<=0, tx_start<=0, timer<=0, state<=WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> state<=WAIT_DONE.
  - Otherwise the timer increments. When the timer reaches START_TIMEOUT-1 with tx_busy still 0: err<=1 for one cycle, state<=IDLE, byte_count unchanged. The byte is dropped and not retried.
- WAIT_DONE: when tx_busy=0, state<=IDLE, done<=1 for one cycle, byte_count<=byte_count+1 (modular).
- A requester that drops req in the same cycle it would be granted is not granted: selection uses req as sampled on that edge.
- A requester re-asserting immediately after ack is eligible only after the pointer has passed it. No requester is granted twice while another requester is waiting.
- req changes after the grant have no effect on tx_data.
- tx_data holds its value after return to IDLE until the next grant.
- grant_id >= N_REQ never occurs.

Test Plan:
1. Reset: rst=1 for 3 cycles with req=4'b1111 -> ack=0, tx_start=0, state=0, byte_count=0, idle=1. Release rst -> ack=4'b0001 and tx_start=1 in the cycle after the first sample.
2. Single send: req[2]=1, data 8'h53, tx_busy model rises 2 cycles after tx_start and stays high 1250*10 cycles -> tx_data=8'h53, grant_id=2, done pulses once when busy falls, byte_count=1.
3. Round-robin: req=4'b1111 held with data 8'h6E/8'h61/8'h70/8'hFF -> grant order 0,1,2,3,0 and tx_data sequence 6E,61,70,FF,6E. byte_count=4 after four frames.
4. Fairness: req[0] permanently high, req[3] asserted mid-frame -> the next grant goes to 3, not 0.
5. Timeout: tx_busy tied 0, req[1]=1 -> err pulses exactly START_TIMEOUT+1 cycles after tx_start, state returns to 0, byte_count unchanged. The next grant goes to requester 2 if requested, else 1.
6. Corner cases:
   - Reset asserted during WAIT_DONE -> state=0 next edge, byte_count=0.
   - tx_busy=1 while IDLE with req pending -> no ack until tx_busy=0.
   - byte_count preset path: run 2^14 frames with CNT_W=4 override (16 frames) -> wraps to 0.
